// File: rtl/fp32_addsub_core.sv
// Multi-cycle fp32 add/subtract datapath for finite operands; denormals flush to zero.
// Zero/Inf/NaN results are overridden downstream, so temp_result is don't-care for them.
//
// state | meaning
// IDLE  | waiting for start; captures and unpacks operands
// ALIGN | order operands by magnitude, right-shift smaller mantissa
// ADD   | 28-bit add/subtract, carry-out renormalised here
// NORM  | left-normalise one bit per cycle (bounded by NORM_MAX)
// ROUND | round-to-nearest-even, exponent overflow to Inf
// DONE  | valid pulse
module fp32_addsub_core #(
  parameter int NORM_MAX = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        valid,
  output logic [31:0] A_out,
  output logic [31:0] B_out,
  output logic [31:0] temp_result
);

  localparam int CW = $clog2(NORM_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [31:0]   a_out_q, a_out_d;
  logic [31:0]   b_out_q, b_out_d;
  logic [31:0]   temp_q, temp_d;
  logic          sx_q, sx_d, sy_q, sy_d;
  logic [7:0]    ex_q, ex_d, ey_q, ey_d;
  logic [26:0]   mx_q, mx_d, my_q, my_d;
  logic [9:0]    e_q, e_d;
  logic          sign_q, sign_d;
  logic [26:0]   mant_q, mant_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // align helpers
  logic          x_is_a;
  logic [7:0]    e_big, e_small, sh_d;
  logic [26:0]   m_big, m_small, m_shift, lost_mask;
  logic          s_big, s_small;

  // add / round helpers
  logic          eff_sub;
  logic [27:0]   sum;
  logic          rnd_up;
  logic [24:0]   m_rnd;
  logic [9:0]    e_rnd;
  logic [22:0]   f_rnd;

  always_comb begin
    x_is_a    = {ex_q, mx_q} >= {ey_q, my_q};
    s_big     = x_is_a ? sx_q : sy_q;
    s_small   = x_is_a ? sy_q : sx_q;
    e_big     = x_is_a ? ex_q : ey_q;
    e_small   = x_is_a ? ey_q : ex_q;
    m_big     = x_is_a ? mx_q : my_q;
    m_small   = x_is_a ? my_q : mx_q;
    sh_d      = e_big - e_small;
    lost_mask = ~({27{1'b1}} << sh_d);
    if (sh_d >= 8'd27) begin
      m_shift = {26'd0, |m_small};
    end else begin
      m_shift = (m_small >> sh_d) | {26'd0, |(m_small & lost_mask)};
    end

    eff_sub = sx_q ^ sy_q;
    sum     = eff_sub ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});

    rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    m_rnd  = {1'b0, mant_q[26:3]} + {24'd0, rnd_up};
    e_rnd  = m_rnd[24] ? (e_q + 10'd1) : e_q;
    f_rnd  = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
  end

  always_comb begin
    state_d = state_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    temp_d  = temp_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    mx_d    = mx_q;
    my_d    = my_q;
    e_d     = e_q;
    sign_d  = sign_q;
    mant_d  = mant_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_out_d = A;
          b_out_d = {B[31] ^ op, B[30:0]};
          sx_d    = A[31];
          sy_d    = B[31] ^ op;
          ex_d    = A[30:23];
          ey_d    = B[30:23];
          mx_d    = (A[30:23] == 8'd0) ? 27'd0 : {1'b1, A[22:0], 3'b000};
          my_d    = (B[30:23] == 8'd0) ? 27'd0 : {1'b1, B[22:0], 3'b000};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sx_d    = s_big;
        sy_d    = s_small;
        mx_d    = m_big;
        my_d    = m_shift;
        e_d     = {2'd0, e_big};
        state_d = S_ADD;
      end
      S_ADD: begin
        sign_d = sx_q;
        zero_d = 1'b0;
        cnt_d  = CW'(NORM_MAX);
        if (sum[27]) begin
          mant_d = {sum[27:2], sum[1] | sum[0]};
          e_d    = e_q + 10'd1;
        end else begin
          mant_d = sum[26:0];
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mant_q == 27'd0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          state_d = S_ROUND;
        end else if (!mant_q[26]) begin
          if (e_q > 10'd1 && cnt_q != '0) begin
            mant_d = {mant_q[25:0], 1'b0};
            e_d    = e_q - 10'd1;
            cnt_d  = cnt_q - 1'b1;
          end else begin
            // underflow or exhausted shift budget: flush to +0
            zero_d  = 1'b1;
            sign_d  = 1'b0;
            state_d = S_ROUND;
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (zero_q) begin
          temp_d = 32'd0;
        end else if (e_rnd >= 10'd255) begin
          temp_d = {sign_q, 8'hFF, 23'd0};
        end else begin
          temp_d = {sign_q, e_rnd[7:0], f_rnd};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_out_q <= '0;
      b_out_q <= '0;
      temp_q  <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      temp_q  <= temp_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      mant_q  <= mant_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign valid       = (state_q == S_DONE);
  assign A_out       = a_out_q;
  assign B_out       = b_out_q;
  assign temp_result = temp_q;

endmodule

// File: tb/tb_fp32_addsub_core.sv
// Directed bench for fp32_addsub_core: results, latency, handshake and async reset abort.
module tb_fp32_addsub_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        valid;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic [31:0] temp_result;

  int total = 0;
  int bad   = 0;

  fp32_addsub_core #(.NORM_MAX(26)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .valid       (valid),
    .A_out       (A_out),
    .B_out       (B_out),
    .temp_result (temp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one operation from just after an edge; returns edges counted until valid (60 = timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                       output int lat, output logic [31:0] res,
                       output logic [31:0] aout, output logic [31:0] bout);
    logic got;
    A = a; B = b; op = o; start = 1'b1;
    lat = 0; got = 1'b0; res = '0; aout = '0; bout = '0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (valid) begin
        got  = 1'b1;
        res  = temp_result;
        aout = A_out;
        bout = B_out;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  int          nval;
  logic [31:0] res, aout, bout;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
    #2;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_aout",  A_out,          32'd0);
    chk("rst_bout",  B_out,          32'd0);
    chk("rst_res",   temp_result,    32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat, res, aout, bout);
    chk("one_plus_one_res", res, 32'h40000000);
    chk("one_plus_one_lat", lat, 5);
    chk("one_plus_one_aout", aout, 32'h3F800000);
    chk("one_plus_one_bout", bout, 32'h3F800000);
    chk("idle_after_done", {31'd0, busy}, 32'd0);

    do_op(32'h3F800000, 32'h3F400000, 1'b1, lat, res, aout, bout);
    chk("one_minus_3q_res", res, 32'h3E800000);
    chk("one_minus_3q_lat", lat, 7);
    chk("one_minus_3q_bout", bout, 32'hBF400000);

    do_op(32'h3F800000, 32'h40000000, 1'b1, lat, res, aout, bout);
    chk("one_minus_two_res", res, 32'hBF800000);
    chk("one_minus_two_lat", lat, 6);
    chk("one_minus_two_bout", bout, 32'hC0000000);

    do_op(32'h3F800000, 32'h33800000, 1'b0, lat, res, aout, bout);
    chk("tie_even_down", res, 32'h3F800000);
    do_op(32'h3F800001, 32'h33800000, 1'b0, lat, res, aout, bout);
    chk("tie_even_up", res, 32'h3F800002);

    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat, res, aout, bout);
    chk("overflow_inf", res, 32'h7F800000);
    do_op(32'h40490FDB, 32'h40490FDB, 1'b1, lat, res, aout, bout);
    chk("cancel_zero", res, 32'h00000000);
    chk("cancel_lat", lat, 5);

    // start pulsed while busy must be ignored
    A = 32'h3F800000; B = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 32'h40000000; B = 32'h40400000; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nval = 0; res = '0; aout = '0;
    for (int i = 0; i < 15; i++) begin
      if (valid) begin
        nval++;
        res  = temp_result;
        aout = A_out;
      end
      @(posedge clk); #1;
    end
    chk("busy_start_nvalid", nval, 1);
    chk("busy_start_res", res, 32'h40000000);
    chk("busy_start_aout", aout, 32'h3F800000);

    // async reset during NORM (1 - 0.75 needs two shifts)
    A = 32'h3F800000; B = 32'h3F400000; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_aout",  A_out,          32'd0);
    chk("abort_bout",  B_out,          32'd0);
    chk("abort_res",   temp_result,    32'd0);
    nval = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid) nval++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid) nval++;
    end
    chk("abort_no_valid", nval, 0);

    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat, res, aout, bout);
    chk("after_reset_res", res, 32'h40000000);
    chk("after_reset_lat", lat, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_addsub_core.md
Name: fp32_addsub_core

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract datapath.
- Computes the finite-operand result `temp_result` and feeds the downstream special-case resolver.
- Also supplies the registered operand pair that the resolver needs: A unchanged, B with its sign flipped when subtracting.
- Does not handle zero, Inf or NaN. The downstream stage overrides those cases.
- Denormals are flushed to zero on input and output.

Parameters:
- NORM_MAX, 26, maximum left-normalise iterations before the result is forced to zero (safety bound; a legal datapath never reaches it).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = A+B, 1 = A-B
- A  input  32  operand A, fp32
- B  input  32  operand B, fp32
- busy  output  1  high from the edge accepting start until the edge ending DONE
- valid  output  1  one-cycle pulse; temp_result, A_out and B_out are valid while high
- A_out  output  32  captured A
- B_out  output  32  captured B, with bit 31 inverted when op=1
- temp_result  output  32  rounded result for finite operands

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, valid=0, A_out=0, B_out=0, temp_result=0, all internal registers 0.
  - Reset asserted mid-operation aborts the operation. No valid pulse is produced for it.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - If start=1 at the edge: capture A_out and B_out (with the op sign flip), unpack both operands, go to ALIGN.
  - Unpack: mantissa = {hidden, frac, 3'b000}, i.e. 27 bits with guard, round and sticky.
  - hidden = 0 and mantissa = 0 when exp = 0 (flush).
- start while busy: ignored, not queued.
- ALIGN (1 cycle):
  - Swap so the larger-magnitude operand (by exp, then mantissa) is X.
  - Right-shift Y's mantissa by d = expX - expY. If d >= 27, Y becomes 0 with sticky = OR of Y.
  - Shifted-out bits OR into the sticky bit (LSB).
  - Result exponent E = expX.
- ADD (1 cycle):
  - Effective subtract = signX XOR signY_eff.
  - Compute 28-bit sum or difference. Result sign = signX.
  - Carry-out (bit 27) forces one right shift with sticky preserved, E+1, in this cycle.
- NORM (>= 1 cycle):
  - Each cycle: if mant[26]=0, mant != 0 and E > 1, shift left 1 and E-1. Otherwise go to ROUND.
  - mant = 0: result is exactly +0 (sign forced 0), go to ROUND.
  - E reaching 1 with mant[26]=0: underflow, flush to +0.
  - Counter exceeding NORM_MAX: force +0.
- ROUND (1 cycle):
  - Round to nearest, ties to even, on G/R/S.
  - Mantissa overflow after rounding renormalises with E+1.
  - E >= 255: temp_result = {sign, 8'hFF, 23'h0}.
- DONE (1 cycle): valid=1, busy still 1, then go to IDLE (busy=0 next cycle).
- Latency from the start-accepting edge to valid high is 5+k cycles, where k = number of NORM left shifts (0..NORM_MAX). Back-to-back operations are possible: start can be accepted in the first IDLE cycle after DONE.
- Outputs hold their last values between operations. They are meaningful only while valid=1.
- Special operands (exp = 255, or zero) follow the same datapath. temp_result is deterministic but don't-care; the downstream stage replaces it.

Test Plan:
- A=3F800000, B=3F800000, op=0 → temp_result=40000000, valid exactly 5 cycles after start, B_out=3F800000.
- A=3F800000, B=3F400000, op=1 → temp_result=3E800000, k=2 so latency 7, B_out=BF400000.
- Rounding: A=3F800000 + B=33800000 → 3F800000 (tie to even). A=3F800001 + B=33800000 → 3F800002.
- Overflow: A=7F7FFFFF + B=7F7FFFFF, op=0 → temp_result=7F800000. Cancellation: A=40490FDB - B=40490FDB → 00000000.
- Handshake and reset:
  - start pulsed while busy → ignored, single valid.
  - rst_n dropped during NORM → all outputs 0 immediately, no valid.
  - A new start after release completes normally.
